// File: rtl/stream_downsizer_if.sv
// stream_downsizer_if: word-in / beat-out handshake bundle for stream_downsizer
interface stream_downsizer_if #(
    parameter int IN_WIDTH = 32,
    parameter int OUT_WIDTH = 8
);
    localparam int BW = $clog2(IN_WIDTH / OUT_WIDTH) + 1;
    logic                 in_valid_i;
    logic                 in_ready_o;
    logic [IN_WIDTH-1:0]  in_data_i;
    logic [BW-1:0]        in_beats_i;
    logic                 out_valid_o;
    logic                 out_ready_i;
    logic [OUT_WIDTH-1:0] out_data_o;
    logic                 out_last_o;
    modport master (
        output in_valid_i, in_data_i, in_beats_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_data_o, out_last_o
    );
    modport slave (
        input  in_valid_i, in_data_i, in_beats_i, out_ready_i,
        output in_ready_o, out_valid_o, out_data_o, out_last_o
    );
endinterface

// File: rtl/stream_downsizer.sv
// stream_downsizer: splits wide words into LSB-first narrow beats with a per-word beat count
module stream_downsizer #(
    parameter int IN_WIDTH = 32,
    parameter int OUT_WIDTH = 8
) (
    input logic clk,
    input logic rst,
    stream_downsizer_if.slave bus
);
    localparam int RATIO = IN_WIDTH / OUT_WIDTH;
    localparam int BW = $clog2(RATIO) + 1;
    localparam int IW = $clog2(RATIO);
    if (IN_WIDTH % OUT_WIDTH != 0 || RATIO < 2) begin : g_bad_ratio
        $error("stream_downsizer: IN_WIDTH must be a multiple (>=2) of OUT_WIDTH");
    end
    typedef enum logic {IDLE, BUSY} state_t;
    state_t state, state_nx;
    logic [IN_WIDTH-1:0] word;
    logic [IW-1:0] idx;
    logic [BW-1:0] n, nb;
    logic last, xfer_in, xfer_out;
    always_ff @(posedge clk) state <= rst ? IDLE : state_nx;
    always_comb state_nx = xfer_in ? BUSY : (xfer_out && last) ? IDLE : state;
    // Last-beat handoff keeps in_ready_o high so the next word loads with no bubble
    always_comb begin
        last = state == BUSY && BW'(idx) == n - BW'(1);
        bus.out_valid_o = state == BUSY && !rst;
        bus.out_last_o = last && !rst;
        bus.out_data_o = rst ? '0 : word[idx*OUT_WIDTH +: OUT_WIDTH];
        xfer_out = bus.out_valid_o && bus.out_ready_i;
        bus.in_ready_o = state == IDLE || rst || (xfer_out && last);
        xfer_in = bus.in_valid_i && bus.in_ready_o;
        nb = (bus.in_beats_i == '0 || bus.in_beats_i > BW'(RATIO)) ? BW'(RATIO) : bus.in_beats_i;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            word <= '0;
            idx <= '0;
            n <= '0;
        end else if (xfer_in) begin
            word <= bus.in_data_i;
            idx <= '0;
            n <= nb;
        end else if (xfer_out && !last) begin
            idx <= idx + IW'(1);
        end
    end
endmodule

// File: tb/tb_stream_downsizer.sv
// tb_stream_downsizer: directed checks of beat order, last, handoff, backpressure and reset
module tb_stream_downsizer;
    logic clk, rst;
    int tests = 0, fails = 0;
    stream_downsizer_if #(.IN_WIDTH(32), .OUT_WIDTH(8)) bus();
    stream_downsizer #(.IN_WIDTH(32), .OUT_WIDTH(8)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
    initial clk = 0;
    always #5 clk = ~clk;
    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask
    task automatic idle_chk(input string tag);
        #1;
        chk({tag, "_valid"}, 32'(bus.out_valid_o), 0);
        chk({tag, "_rdy"}, 32'(bus.in_ready_o), 1);
        cyc();
    endtask
    task automatic load(input string tag, input logic [31:0] d, input logic [2:0] b);
        bus.in_valid_i = 1;
        bus.in_data_i = d;
        bus.in_beats_i = b;
        #1;
        chk({tag, "_load_rdy"}, 32'(bus.in_ready_o), 1);
        cyc();
        bus.in_valid_i = 0;
        bus.in_data_i = 32'hDEADBEEF;
        bus.in_beats_i = 3'd1;
    endtask
    task automatic beat(input string tag, input logic [7:0] d, input logic l, input logic r);
        #1;
        chk({tag, "_valid"}, 32'(bus.out_valid_o), 1);
        chk({tag, "_data"}, 32'(bus.out_data_o), 32'(d));
        chk({tag, "_last"}, 32'(bus.out_last_o), 32'(l));
        chk({tag, "_rdy"}, 32'(bus.in_ready_o), 32'(r));
        cyc();
    endtask
    initial begin
        rst = 1;
        bus.in_valid_i = 0;
        bus.in_data_i = 32'h12345678;
        bus.in_beats_i = 3'd4;
        bus.out_ready_i = 1;
        cyc();
        cyc();
        chk("rst_valid", 32'(bus.out_valid_o), 0);
        chk("rst_last", 32'(bus.out_last_o), 0);
        chk("rst_data", 32'(bus.out_data_o), 0);
        chk("rst_rdy", 32'(bus.in_ready_o), 1);
        rst = 0;
        idle_chk("idle0");
        load("full", 32'hDDCCBBAA, 3'd4);
        beat("full0", 8'hAA, 0, 0);
        beat("full1", 8'hBB, 0, 0);
        beat("full2", 8'hCC, 0, 0);
        beat("full3", 8'hDD, 1, 1);
        idle_chk("full_end");
        load("part", 32'h44332211, 3'd2);
        beat("part0", 8'h11, 0, 0);
        beat("part1", 8'h22, 1, 1);
        idle_chk("part_end");
        load("b2b_a", 32'h03020100, 3'd4);
        bus.in_valid_i = 1;
        bus.in_data_i = 32'h07060504;
        bus.in_beats_i = 3'd4;
        beat("b2b0", 8'h00, 0, 0);
        beat("b2b1", 8'h01, 0, 0);
        beat("b2b2", 8'h02, 0, 0);
        beat("b2b3", 8'h03, 1, 1);
        bus.in_valid_i = 0;
        bus.in_data_i = 32'hDEADBEEF;
        beat("b2b4", 8'h04, 0, 0);
        beat("b2b5", 8'h05, 0, 0);
        beat("b2b6", 8'h06, 0, 0);
        beat("b2b7", 8'h07, 1, 1);
        idle_chk("b2b_end");
        load("bp", 32'hDDCCBBAA, 3'd4);
        beat("bp0", 8'hAA, 0, 0);
        bus.out_ready_i = 0;
        beat("bp_hold0", 8'hBB, 0, 0);
        beat("bp_hold1", 8'hBB, 0, 0);
        beat("bp_hold2", 8'hBB, 0, 0);
        bus.out_ready_i = 1;
        beat("bp1", 8'hBB, 0, 0);
        beat("bp2", 8'hCC, 0, 0);
        beat("bp3", 8'hDD, 1, 1);
        idle_chk("bp_end");
        load("mid", 32'hDDCCBBAA, 3'd4);
        beat("mid0", 8'hAA, 0, 0);
        beat("mid1", 8'hBB, 0, 0);
        rst = 1;
        #1;
        chk("mid_rst_valid", 32'(bus.out_valid_o), 0);
        chk("mid_rst_last", 32'(bus.out_last_o), 0);
        chk("mid_rst_rdy", 32'(bus.in_ready_o), 1);
        cyc();
        rst = 0;
        #1;
        chk("mid_after_data", 32'(bus.out_data_o), 0);
        idle_chk("mid_after0");
        idle_chk("mid_after1");
        idle_chk("mid_after2");
        load("zero", 32'hDDCCBBAA, 3'd0);
        beat("zero0", 8'hAA, 0, 0);
        beat("zero1", 8'hBB, 0, 0);
        beat("zero2", 8'hCC, 0, 0);
        beat("zero3", 8'hDD, 1, 1);
        idle_chk("zero_end");
        load("big", 32'h87654321, 3'd7);
        beat("big0", 8'h21, 0, 0);
        beat("big1", 8'h43, 0, 0);
        beat("big2", 8'h65, 0, 0);
        beat("big3", 8'h87, 1, 1);
        idle_chk("big_end");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/stream_downsizer.md
STREAM_DOWNSIZER -- requirements
Module: stream_downsizer

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 32: input word width in bits.
REQ-002 SHALL have parameter OUT_WIDTH, default 8: output beat width in bits.
REQ-003 SHALL derive RATIO = IN_WIDTH/OUT_WIDTH and BW = $clog2(RATIO)+1; elaboration SHALL fail unless IN_WIDTH % OUT_WIDTH == 0 and RATIO >= 2.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port in_valid_i  input  1  upstream word valid.
REQ-007 SHALL have port in_ready_o  output  1  block accepts word this cycle.
REQ-008 SHALL have port in_data_i  input  IN_WIDTH  input word; beat 0 is bits [OUT_WIDTH-1:0].
REQ-009 SHALL have port in_beats_i  input  BW  number of valid beats in the word, legal 1..RATIO.
REQ-010 SHALL have port out_valid_o  output  1  output beat valid.
REQ-011 SHALL have port out_ready_i  input  1  downstream accepts beat (typically a skid_buffer in_ready_o).
REQ-012 SHALL have port out_data_o  output  OUT_WIDTH  current beat.
REQ-013 SHALL have port out_last_o  output  1  high on the final beat of the current word.

Function
REQ-014 SHALL transfer a word on in_valid_i && in_ready_o, and a beat on out_valid_o && out_ready_i.
REQ-015 SHALL hold a one-word register, a beat index idx (0..RATIO-1), a count of beats n, and state IDLE/BUSY.
REQ-016 SHALL drive in_ready_o = (state==IDLE) || (out_valid_o && out_ready_i && out_last_o), combinationally; no bubble between words.
REQ-017 SHALL, on input transfer, capture in_data_i and n, set idx=0, and enter BUSY; the first beat is valid the next cycle (latency 1).
REQ-018 SHALL treat in_beats_i of 0 or > RATIO as RATIO.
REQ-019 SHALL drive out_valid_o = (state==BUSY), registered-state based, with no combinational path from in_valid_i to out_valid_o.
REQ-020 SHALL drive out_data_o = word[idx*OUT_WIDTH +: OUT_WIDTH], emitting beats LSB-first.
REQ-021 SHALL drive out_last_o = BUSY && (idx == n-1).
REQ-022 SHALL hold out_data_o, out_last_o and out_valid_o stable while out_valid_o && !out_ready_i.
REQ-023 SHALL increment idx on each non-last output transfer.
REQ-024 SHALL, on a last-beat transfer without simultaneous input transfer, return to IDLE.
REQ-025 SHALL, when a last-beat transfer and an input transfer occur in the same cycle, load the new word, reset idx to 0 and stay BUSY.
REQ-026 SHALL sustain one output beat per cycle while out_ready_i=1 and input words are available.
REQ-027 SHALL ignore in_data_i and in_beats_i whenever no input transfer occurs.

Reset
REQ-028 SHALL, while rst=1 at a rising edge, set state=IDLE, idx=0, n=0 and word register=0.
REQ-029 SHALL, while rst=1, drive out_valid_o=0, out_last_o=0, out_data_o=0 and in_ready_o=1.
REQ-030 SHALL, on reset mid-word, discard remaining beats; no beat of that word appears after rst deasserts.

Verification
REQ-031 Bench SHALL cover full word: IN=32/OUT=8, word 0xDDCCBBAA, beats=4, out_ready_i=1 -> beats 0xAA,0xBB,0xCC,0xDD on cycles N+1..N+4, last only on 0xDD.
REQ-032 Bench SHALL cover partial word: beats=2, word 0x44332211 -> 0x11 then 0x22 with last; 0x33/0x44 never emitted.
REQ-033 Bench SHALL cover back-to-back words: 0x03020100 and 0x07060504 offered continuously -> 8 beats 0x00..0x07 on 8 consecutive cycles, in_ready_o high only in the cycle of each last beat or IDLE.
REQ-034 Bench SHALL cover backpressure: out_ready_i low for 3 cycles during beat 1 of 0xDDCCBBAA -> 0xBB held stable, no beat lost or duplicated.
REQ-035 Bench SHALL cover reset mid-word: rst pulsed after beat 0xBB transfers -> out_valid_o=0 next cycle and no 0xCC/0xDD; in_ready_o=1.
REQ-036 Bench SHALL cover out-of-range beats: in_beats_i=0 and in_beats_i=7 -> each treated as 4 beats.
